// File: rtl/result_serializer_pkg.sv
// Shared constants and types for the compressor result serializer.
package result_serializer_pkg;

    // Number of single-bit result columns (dst0..dst25).
    localparam int NUM_DST = 26;

    // Default width of the completed-frame counter.
    localparam int CNT_W_DEFAULT = 16;

    // Width of the bit index into a snapshot.
    localparam int IDX_W = $clog2(NUM_DST);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/result_piso.sv
// Parallel-load snapshot register with an index mux selecting the current serial bit.
module result_piso
    import result_serializer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [NUM_DST-1:0] load_data,
    input  logic               advance,
    output logic               bit_out,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_DST-1:0] snap;

    // Capture the result columns on load; step the index on each accepted non-final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap <= '0;
            idx  <= '0;
        end else if (load) begin
            snap <= load_data;
            idx  <= '0;
        end else if (advance) begin
            idx  <= idx + IDX_W'(1);
        end
    end

    // Current bit comes straight from registered state, never from the handshake.
    always_comb begin
        bit_out = snap[idx];
    end

endmodule

// File: rtl/result_serializer.sv
// Snapshots the 26 compressor result columns and streams them LSB-first
// over a 1-bit valid/ready interface with frame-last marking and a frame counter.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dst0,  input logic dst1,  input logic dst2,  input logic dst3,
    input  logic             dst4,  input logic dst5,  input logic dst6,  input logic dst7,
    input  logic             dst8,  input logic dst9,  input logic dst10, input logic dst11,
    input  logic             dst12, input logic dst13, input logic dst14, input logic dst15,
    input  logic             dst16, input logic dst17, input logic dst18, input logic dst19,
    input  logic             dst20, input logic dst21, input logic dst22, input logic dst23,
    input  logic             dst24, input logic dst25,
    input  logic             start,
    output logic             ser_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy,
    output logic             frame_done,
    output logic             start_dropped,
    output logic [CNT_W-1:0] frame_count
);

    state_t             state;
    logic [NUM_DST-1:0] dst_bus;
    logic [IDX_W-1:0]   idx;
    logic               cur_bit;
    logic               at_last;
    logic               load;
    logic               advance;

    assign dst_bus = {dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18, dst17,
                      dst16, dst15, dst14, dst13, dst12, dst11, dst10, dst9,  dst8,
                      dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0};

    assign at_last = (idx == IDX_W'(NUM_DST - 1));
    assign load    = (state == IDLE) && start;
    assign advance = (state == SHIFT) && ser_ready && !at_last;

    result_piso u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (dst_bus),
        .advance   (advance),
        .bit_out   (cur_bit),
        .idx       (idx)
    );

    // Serial outputs are decoded from registers only; data is forced low outside a frame.
    always_comb begin
        ser_data = ser_valid & cur_bit;
        ser_last = ser_valid & at_last;
    end

    // Frame FSM: accepts start in IDLE, counts the final handshake, flags starts that arrive mid-frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ser_valid     <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            start_dropped <= 1'b0;
            frame_count   <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= SHIFT;
                        ser_valid <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (start) begin
                        start_dropped <= 1'b1;
                    end
                    if (ser_ready && at_last) begin
                        state       <= IDLE;
                        ser_valid   <= 1'b0;
                        busy        <= 1'b0;
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    ser_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: a default instance plus a 2-bit counter instance sharing stimulus.
module tb_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ser_ready;
    logic [25:0] dst;

    logic        a_data, a_valid, a_last, a_busy, a_done, a_drop;
    logic [15:0] a_count;
    logic        b_data, b_valid, b_last, b_busy, b_done, b_drop;
    logic [1:0]  b_count;

    int n_assert = 0;
    int n_fail   = 0;
    int frames   = 0;

    always #5 clk = ~clk;

    result_serializer dut (
        .clk(clk), .rst(rst),
        .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),
        .dst4(dst[4]),   .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),
        .dst8(dst[8]),   .dst9(dst[9]),   .dst10(dst[10]), .dst11(dst[11]),
        .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]), .dst15(dst[15]),
        .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
        .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]),
        .dst24(dst[24]), .dst25(dst[25]),
        .start(start), .ser_data(a_data), .ser_valid(a_valid), .ser_ready(ser_ready),
        .ser_last(a_last), .busy(a_busy), .frame_done(a_done),
        .start_dropped(a_drop), .frame_count(a_count)
    );

    result_serializer #(.CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst),
        .dst0(dst[0]),   .dst1(dst[1]),   .dst2(dst[2]),   .dst3(dst[3]),
        .dst4(dst[4]),   .dst5(dst[5]),   .dst6(dst[6]),   .dst7(dst[7]),
        .dst8(dst[8]),   .dst9(dst[9]),   .dst10(dst[10]), .dst11(dst[11]),
        .dst12(dst[12]), .dst13(dst[13]), .dst14(dst[14]), .dst15(dst[15]),
        .dst16(dst[16]), .dst17(dst[17]), .dst18(dst[18]), .dst19(dst[19]),
        .dst20(dst[20]), .dst21(dst[21]), .dst22(dst[22]), .dst23(dst[23]),
        .dst24(dst[24]), .dst25(dst[25]),
        .start(start), .ser_data(b_data), .ser_valid(b_valid), .ser_ready(ser_ready),
        .ser_last(b_last), .busy(b_busy), .frame_done(b_done),
        .start_dropped(b_drop), .frame_count(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; pulses start across exactly one posedge, returns at the following negedge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Receive one frame starting at the negedge where bit 0 is presented.
    // bp: ready pattern 1,0,0 repeating; drop_at: handshake index at which to pulse start (-1 = none).
    task automatic recv(input string tag, input bit bp, input int drop_at, output logic [25:0] word);
        int   cyc = 0;
        int   hs = 0;
        bit   held = 1'b0;
        logic held_bit = 1'b0;
        bit   dropped_sent = 1'b0;
        word = '0;
        while (hs < 26 && cyc < 300) begin
            ser_ready = bp ? ((cyc % 3) == 0) : 1'b1;
            start = (drop_at >= 0 && hs == drop_at && !dropped_sent);
            if (start) dropped_sent = 1'b1;
            if (held) begin
                chk($sformatf("%s_hold_valid", tag), {31'b0, a_valid}, 32'd1);
                chk($sformatf("%s_hold_data", tag), {31'b0, a_data}, {31'b0, held_bit});
            end
            if (!bp) chk($sformatf("%s_valid_b%0d", tag, hs), {31'b0, a_valid}, 32'd1);
            if (a_valid) chk($sformatf("%s_last_b%0d", tag, hs), {31'b0, a_last}, {31'b0, hs == 25});
            held     = a_valid && !ser_ready;
            held_bit = a_data;
            if (a_valid && ser_ready) begin
                word[hs] = a_data;
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        ser_ready = 1'b0;
        chk($sformatf("%s_handshakes", tag), hs, 32'd26);
        chk($sformatf("%s_done", tag), {31'b0, a_done}, 32'd1);
        chk($sformatf("%s_valid_off", tag), {31'b0, a_valid}, 32'd0);
        chk($sformatf("%s_busy_off", tag), {31'b0, a_busy}, 32'd0);
        frames++;
        chk($sformatf("%s_count", tag), {16'b0, a_count}, frames);
        chk($sformatf("%s_count_w2", tag), {30'b0, b_count}, frames % 4);
    endtask

    logic [25:0] word;

    initial begin
        rst = 1'b1; start = 1'b0; ser_ready = 1'b0; dst = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_data",  {31'b0, a_data},  32'd0);
        chk("rst_valid", {31'b0, a_valid}, 32'd0);
        chk("rst_last",  {31'b0, a_last},  32'd0);
        chk("rst_busy",  {31'b0, a_busy},  32'd0);
        chk("rst_done",  {31'b0, a_done},  32'd0);
        chk("rst_drop",  {31'b0, a_drop},  32'd0);
        chk("rst_count", {16'b0, a_count}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-frame after 5 accepted bits.
        dst = 26'h155_5555;
        ser_ready = 1'b1;
        pulse_start();
        chk("abort_valid_pre", {31'b0, a_valid}, 32'd1);
        repeat (5) @(negedge clk);
        chk("abort_busy_pre", {31'b0, a_busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid_async", {31'b0, a_valid}, 32'd0);
        chk("abort_busy_async",  {31'b0, a_busy},  32'd0);
        chk("abort_count",       {16'b0, a_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, a_done}, 32'd0);
        end

        // Single frame, ready tied high.
        dst = 26'h2AA_AAAA;
        pulse_start();
        chk("single_first_bit", {31'b0, a_data}, 32'd0);
        recv("single", 1'b0, -1, word);
        chk("single_word", {6'b0, word}, 32'h2AA_AAAA);

        // Backpressure.
        @(negedge clk);
        dst = 26'h000_0001;
        pulse_start();
        recv("bp", 1'b1, -1, word);
        chk("bp_word", {6'b0, word}, 32'h000_0001);

        // Snapshot isolation.
        @(negedge clk);
        dst = 26'h3FF_FFFF;
        pulse_start();
        dst = 26'h000_0000;
        recv("iso", 1'b0, -1, word);
        chk("iso_word", {6'b0, word}, 32'h3FF_FFFF);

        // Dropped start mid-frame, then back-to-back start on the frame_done cycle.
        @(negedge clk);
        chk("drop_pre", {31'b0, a_drop}, 32'd0);
        dst = 26'h123_4567;
        pulse_start();
        recv("drop", 1'b0, 10, word);
        chk("drop_word", {6'b0, word}, 32'h123_4567);
        chk("drop_flag", {31'b0, a_drop}, 32'd1);
        dst = 26'h0F0_F0F0;
        pulse_start();
        chk("b2b_valid", {31'b0, a_valid}, 32'd1);
        chk("b2b_busy",  {31'b0, a_busy},  32'd1);
        recv("b2b", 1'b0, -1, word);
        chk("b2b_word", {6'b0, word}, 32'h0F0_F0F0);
        repeat (3) @(negedge clk);
        chk("idle_busy",   {31'b0, a_busy},  32'd0);
        chk("drop_sticky", {31'b0, a_drop},  32'd1);
        chk("w2_final",    {30'b0, b_count}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
Name: result_serializer

Overview:
- Output-side companion to the column-wise input shift register around the 13x13 cascade multiplier compressor.
- Snapshots the 26 single-bit compressor result columns (dst0..dst25) on request.
- Streams the snapshot out LSB-first (dst0 first) over a 1-bit valid/ready serial interface, with frame-last marking and a frame counter.
- Lets the bench or FPGA wrapper check results with few pins, mirroring how operands are shifted in.

Parameters:
- NUM_DST, 26, number of result columns; port list generated to match, so the shipped instance is 26.
- CNT_W, 16, width of the completed-frame counter.

Ports:
- clk  in  1  single clock, all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- dst0..dst25  in  1 each  compressor result columns; dstN is the weight-2^N column.
- start  in  1  one-cycle request to snapshot dst* and begin a frame.
- ser_data  out  1  current serial bit.
- ser_valid  out  1  ser_data holds a valid frame bit.
- ser_ready  in  1  downstream accepts the bit when ser_valid&ser_ready at posedge.
- ser_last  out  1  high with the final bit (index NUM_DST-1) of the frame.
- busy  out  1  frame capture/shift in progress.
- frame_done  out  1  one-cycle pulse after the last bit is accepted.
- start_dropped  out  1  sticky flag: a start arrived while busy; cleared only by rst.
- frame_count  out  CNT_W  number of completed frames, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async, immediate): state=IDLE; snapshot and bit index cleared. All outputs are 0: ser_data, ser_valid, ser_last, busy, frame_done, start_dropped, frame_count.
- States: IDLE, SHIFT.
- IDLE with start=1 at edge T:
  - snapshot <= {dst25..dst0} sampled at T (same-edge capture, no settle delay).
  - idx <= 0; state -> SHIFT.
  - From T+1: busy=1, ser_valid=1, ser_data=snapshot[0].
- SHIFT:
  - ser_data = snapshot[idx]; ser_last = (idx==NUM_DST-1); all are registered or decoded from registers only, with no combinational path from ser_ready.
  - Handshake edge with idx<NUM_DST-1: idx <= idx+1.
  - Handshake edge with idx==NUM_DST-1: state -> IDLE, frame_count <= frame_count+1, frame_done=1 for exactly the next cycle. ser_valid, ser_last and busy drop the next cycle.
  - ser_ready low: hold idx and ser_data indefinitely; ser_valid stays high (no retraction).
- Latency: start edge to first valid bit is 1 cycle. Minimum frame with ser_ready tied high is 26 cycles of valid.
- Start rules:
  - start in SHIFT, including the cycle of the final handshake, is ignored and sets start_dropped.
  - start in IDLE on the same cycle frame_done is high is accepted normally (back-to-back frames, one IDLE cycle gap).
- dst* changes during SHIFT do not affect the frame in flight.
- frame_count wraps from 2^CNT_W-1 to 0 with no flag.
- rst asserted mid-frame aborts it: no frame_done, frame_count cleared.

Decomposition:
- Package result_serializer_pkg:
  - NUM_DST, CNT_W defaults.
  - IDX_W = $clog2(NUM_DST).
  - state enum {IDLE, SHIFT}.
- One natural sub-module, result_piso: NUM_DST-bit parallel-load register plus index mux, with load, advance and bit output. The top holds the FSM, handshake, counters and flags.

Test Plan:
- Reset: rst=1 mid-frame (after 5 bits) -> ser_valid drops without waiting for a clock edge; frame_count=0; no frame_done; next start gives a fresh frame.
- Single frame: dst=26'h2AAAAAA, start pulse, ser_ready=1 -> bits 0,1,0,1,... (bit0=0) on 26 consecutive cycles from T+1; ser_last only on the 26th; frame_done at T+27; frame_count=1.
- Backpressure: dst=26'h0000001, ser_ready toggled 1,0,0,1,... -> ser_data/ser_valid held while ready=0; received word equals 26'h0000001; exactly 26 handshakes.
- Snapshot isolation: start with dst=26'h3FFFFFF, then dst=0 the next cycle -> all 26 received bits are 1.
- Dropped start: start pulsed at bit 10 of a frame -> start_dropped=1 sticky, no second frame; start on the frame_done cycle -> second frame begins next cycle.
- Counter wrap: CNT_W=2, run 5 frames -> frame_count sequence 1,2,3,0,1.
